// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the sequential multiplier state type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD  = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    DONE = 3'd4
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Combinational 32-bit ALU; shifts operate on i_b by i_shamt.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  i_ctrl,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_result,
  output logic        o_zout
);

  // Operation select and zero flag.
  always_comb begin
    o_result = '0;
    case (i_ctrl)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_NOR: o_result = ~(i_a | i_b);
      ALU_SLL: o_result = i_b << i_shamt;
      ALU_SRL: o_result = i_b >> i_shamt;
      default: o_result = '0;
    endcase
    o_zout = (o_result == '0);
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier that time-shares one ALU across accumulate,
// multiplicand-shift and multiplier-shift steps. Produces the low 32 bits.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int EARLY_EXIT = 1,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  mul_state_t        r_state;
  mul_state_t        w_next;
  logic [31:0]       r_acc;
  logic [31:0]       r_mcand;
  logic [31:0]       r_mplier;
  logic [5:0]        r_iter;
  logic [31:0]       r_product;

  logic [3:0]        w_ctrl;
  logic [31:0]       w_a;
  logic [31:0]       w_b;
  logic [4:0]        w_shamt;
  logic [31:0]       w_result;
  logic              w_zout;

  alu u_alu (
    .i_ctrl   (w_ctrl),
    .i_a      (w_a),
    .i_b      (w_b),
    .i_shamt  (w_shamt),
    .o_result (w_result),
    .o_zout   (w_zout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state, ALU operand steering and Moore outputs.
  always_comb begin
    w_next  = r_state;
    w_ctrl  = ALU_ADD;
    w_a     = '0;
    w_b     = '0;
    w_shamt = '0;
    busy    = (r_state != IDLE);
    done    = (r_state == DONE);
    case (r_state)
      IDLE: begin
        if (start)
          w_next = (EARLY_EXIT != 0 && op_b == '0) ? DONE : ADD;
      end
      ADD: begin
        w_a    = r_acc;
        w_b    = r_mplier[0] ? r_mcand : '0;
        w_next = SHL;
      end
      SHL: begin
        w_ctrl  = ALU_SLL;
        w_b     = r_mcand;
        w_shamt = 5'd1;
        w_next  = SHR;
      end
      SHR: begin
        w_ctrl  = ALU_SRL;
        w_b     = r_mplier;
        w_shamt = 5'd1;
        // Early exit keys off the shifted multiplier the ALU is producing now.
        if (EARLY_EXIT != 0) w_next = w_zout ? DONE : ADD;
        else                 w_next = (r_iter == 6'd31) ? DONE : ADD;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath registers and product capture on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_iter    <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc    <= '0;
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_iter   <= '0;
          end
        end
        ADD: r_acc   <= w_result;
        SHL: r_mcand <= w_result;
        SHR: begin
          r_mplier <= w_result;
          r_iter   <= r_iter + 6'd1;
        end
        default: ;
      endcase
      // Zero-multiplier shortcut enters DONE straight from IDLE, before acc is cleared.
      if (w_next == DONE && r_state != DONE)
        r_product <= (r_state == IDLE) ? '0 : r_acc;
    end
  end

  assign product = r_product;

endmodule
